vending_machine_core: RTL and testbench
=======================================

// Module: vending_machine_core
// PURPOSE
//  Coin-operated soda vending controller. Price is 20 cents; accepts nickels (5),
//  dimes (10) and quarters (25), one coin per clock cycle. Once credit reaches or
//  exceeds 20 it pulses o_soda for one cycle and reports change in nickel units.
//  Top-level control block, driven directly by coin-acceptor pulses.
// PARAMETERS
//  none (price fixed at 20 cents; coin values fixed)
// PORTS
//  i_clk      in   1  system clock, rising edge; the only clock
//  i_rstn     in   1  reset, asynchronous, active-low
//  i_nickle   in   1  5-cent coin strobe, one cycle per coin
//  i_dime     in   1  10-cent coin strobe, one cycle per coin
//  i_quarter  in   1  25-cent coin strobe, one cycle per coin
//  o_soda     out  1  dispense pulse, one cycle, registered
//  o_change   out  3  change in nickels (0..4 = 0..20 cents), valid while o_soda=1
// BEHAVIOUR
//  - States (credit held): IDLE=0c, C5=5c, C10=10c, C15=15c. 2-bit state register.
//  - Coin sampled on the rising i_clk edge. Coin value in nickels: N=1, D=2, Q=5.
//  - Simultaneous strobes: priority quarter > dime > nickel; lower coins ignored.
//  - sum = credit + coin value (4-bit, nickels). If sum >= 4:
//    o_soda<=1, o_change<=sum-4, state<=IDLE.
//    Else o_soda<=0, o_change<=0, state<=credit index of sum.
//  - No coin: state holds; o_soda<=0, o_change<=0.
//  - Latency: outputs asserted in the cycle after the edge that samples the coin,
//    held exactly one cycle, then return to 0 unless another dispense follows.
//  - A coin arriving during the o_soda cycle is accepted against credit 0
//    (back-to-back dispense allowed).
//  - Full transition table, change values in nickels:
//    IDLE: N->C5, D->C10, Q->soda chg1
//    C5:   N->C10, D->C15, Q->soda chg2
//    C10:  N->C15, D->soda chg0, Q->soda chg3
//    C15:  N->soda chg0, D->soda chg1, Q->soda chg4
//  - Reset (i_rstn=0, any time incl. mid-transaction): state=IDLE, o_soda=0,
//    o_change=0 immediately. Credit is lost; coins during reset are ignored.
//  - o_change never exceeds 4. Codes 5..7 unused.
//  - No illegal state is reachable; the default branch returns to IDLE with
//    outputs 0.
// STRUCTURE
//  - Package vending_pkg: state enum (IDLE,C5,C10,C15), PRICE_NICKELS=4,
//    coin values NICKEL_V=1, DIME_V=2, QUARTER_V=5, change width 3.
//  - Sub-module vending_coin_decode: priority-encodes the three strobes into
//    coin_valid and coin_value[2:0] (combinational).
//  - Core: next-state/sum logic (combinational) plus one always_ff with async
//    reset for state, o_soda and o_change.
// TESTING
//  - Reset then Q at cycle k -> o_soda=1, o_change=1 at cycle k+1; o_soda=0 at k+2.
//  - N,N,N,N on consecutive cycles -> o_soda stays 0 after coins 1-3;
//    soda, change 0 after coin 4.
//  - D,N (15c) then Q -> soda, change=4 (20c); next cycle o_soda=0, credit 0.
//  - Idle gaps of 0-5 cycles between D and D -> single soda, change 0;
//    credit held across gaps.
//  - Coin during the o_soda cycle (Q then Q back-to-back) -> two consecutive
//    soda pulses, change 1 each.
//  - N,D (15c) then reset pulse, then N -> no soda (credit cleared to 0, now 5c);
//    simultaneous D+Q -> treated as Q.

Source files
------------

// File: rtl/vending_pkg.sv
// Shared types and constants for the vending controller. All money is counted in nickels.
package vending_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        C5   = 2'd1,
        C10  = 2'd2,
        C15  = 2'd3
    } state_t;

    localparam int          CHANGE_W      = 3;
    localparam logic [3:0]  PRICE_NICKELS = 4'd4;
    localparam logic [2:0]  NICKEL_V      = 3'd1;
    localparam logic [2:0]  DIME_V        = 3'd2;
    localparam logic [2:0]  QUARTER_V     = 3'd5;

    // Change owed once the running sum reaches the price; sum never exceeds 8, so it fits.
    function automatic logic [CHANGE_W-1:0] change_of(input logic [3:0] sum);
        logic [3:0] diff;
        diff = sum - PRICE_NICKELS;
        return diff[CHANGE_W-1:0];
    endfunction

endpackage

// File: rtl/vending_coin_decode.sv
// Priority encoder for the coin-acceptor strobes: quarter beats dime beats nickel.
module vending_coin_decode
    import vending_pkg::*;
(
    input  logic       i_nickle,
    input  logic       i_dime,
    input  logic       i_quarter,
    output logic       o_coin_valid,
    output logic [2:0] o_coin_value
);

    always_comb begin
        o_coin_valid = i_nickle | i_dime | i_quarter;
        o_coin_value = 3'd0;
        if (i_quarter) begin
            o_coin_value = QUARTER_V;
        end else if (i_dime) begin
            o_coin_value = DIME_V;
        end else if (i_nickle) begin
            o_coin_value = NICKEL_V;
        end
    end

endmodule

// File: rtl/vending_machine_core.sv
// 20-cent soda controller: accumulates credit in nickels and pulses o_soda with change
// in the cycle after the coin that completes the price.
module vending_machine_core
    import vending_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rstn,
    input  logic                i_nickle,
    input  logic                i_dime,
    input  logic                i_quarter,
    output logic                o_soda,
    output logic [CHANGE_W-1:0] o_change
);

    logic                w_coin_valid;
    logic [2:0]          w_coin_value;
    logic [3:0]          w_credit;
    logic [3:0]          w_sum;
    logic                w_legal;
    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_soda;
    logic                w_soda_nxt;
    logic [CHANGE_W-1:0] r_change;
    logic [CHANGE_W-1:0] w_change_nxt;

    vending_coin_decode u_decode (
        .i_nickle     (i_nickle),
        .i_dime       (i_dime),
        .i_quarter    (i_quarter),
        .o_coin_valid (w_coin_valid),
        .o_coin_value (w_coin_value)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_soda_nxt   = 1'b0;
        w_change_nxt = '0;
        w_credit     = 4'd0;
        w_legal      = 1'b1;
        case (r_state)
            IDLE:    w_credit = 4'd0;
            C5:      w_credit = 4'd1;
            C10:     w_credit = 4'd2;
            C15:     w_credit = 4'd3;
            default: w_legal  = 1'b0;
        endcase
        w_sum = w_credit + {1'b0, w_coin_value};

        if (!w_legal) begin
            w_state_nxt = IDLE;
        end else if (w_coin_valid) begin
            if (w_sum >= PRICE_NICKELS) begin
                w_soda_nxt   = 1'b1;
                w_change_nxt = change_of(w_sum);
                w_state_nxt  = IDLE;
            end else begin
                // Below the price the sum is at most 3, so it maps directly onto a credit state.
                w_state_nxt = state_t'(w_sum[1:0]);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state  <= IDLE;
            r_soda   <= 1'b0;
            r_change <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_soda   <= w_soda_nxt;
            r_change <= w_change_nxt;
        end
    end

    assign o_soda   = r_soda;
    assign o_change = r_change;

endmodule

// File: tb/tb_vending_machine_core.sv
// Bench for vending_machine_core: transition table vectors plus hand-built corner sequences.
module tb_vending_machine_core;

    logic       i_clk = 1'b0;
    logic       i_rstn = 1'b0;
    logic       i_nickle = 1'b0;
    logic       i_dime = 1'b0;
    logic       i_quarter = 1'b0;
    logic       o_soda;
    logic [2:0] o_change;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [2:0] coin;   // {q, d, n}
        logic       soda;
        logic [2:0] chg;
    } vec_t;

    typedef struct {
        logic       soda;
        logic [2:0] chg;
        string      tag;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[23];

    localparam logic [2:0] NO = 3'b000;
    localparam logic [2:0] CN = 3'b001;
    localparam logic [2:0] CD = 3'b010;
    localparam logic [2:0] CQ = 3'b100;

    vending_machine_core dut (
        .i_clk     (i_clk),
        .i_rstn    (i_rstn),
        .i_nickle  (i_nickle),
        .i_dime    (i_dime),
        .i_quarter (i_quarter),
        .o_soda    (o_soda),
        .o_change  (o_change)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic step(input logic [2:0] c, input logic es, input logic [2:0] ec, input string tag);
        exp_t e;
        @(negedge i_clk);
        {i_quarter, i_dime, i_nickle} = c;
        e.soda = es;
        e.chg  = ec;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    task automatic rst_pulse();
        @(negedge i_clk);
        {i_quarter, i_dime, i_nickle} = NO;
        i_rstn = 1'b0;
        #1;
        chk("rst_pulse_soda", {3'b0, o_soda}, 4'd0);
        chk("rst_pulse_chg", {1'b0, o_change}, 4'd0);
        @(negedge i_clk);
        i_rstn = 1'b1;
    endtask

    // Scoreboard monitor: each entry was pushed for the coin sampled at this edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge i_clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk({e.tag, "_soda"}, {3'b0, o_soda}, {3'b0, e.soda});
                chk({e.tag, "_chg"}, {1'b0, o_change}, {1'b0, e.chg});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{CN, 1'b0, 3'd0};       // IDLE -> C5
        tbl[1]  = '{CN, 1'b0, 3'd0};       // C5 -> C10
        tbl[2]  = '{CN, 1'b0, 3'd0};       // C10 -> C15
        tbl[3]  = '{CN, 1'b1, 3'd0};       // C15 N -> soda 0
        tbl[4]  = '{CD, 1'b0, 3'd0};       // IDLE -> C10
        tbl[5]  = '{CD, 1'b1, 3'd0};       // C10 D -> soda 0
        tbl[6]  = '{CN, 1'b0, 3'd0};       // C5
        tbl[7]  = '{CD, 1'b0, 3'd0};       // C5 D -> C15
        tbl[8]  = '{CD, 1'b1, 3'd1};       // C15 D -> soda 1
        tbl[9]  = '{CN, 1'b0, 3'd0};       // C5
        tbl[10] = '{CQ, 1'b1, 3'd2};       // C5 Q -> soda 2
        tbl[11] = '{CD, 1'b0, 3'd0};       // C10
        tbl[12] = '{CQ, 1'b1, 3'd3};       // C10 Q -> soda 3
        tbl[13] = '{CD, 1'b0, 3'd0};       // C10
        tbl[14] = '{CN, 1'b0, 3'd0};       // C15
        tbl[15] = '{CQ, 1'b1, 3'd4};       // C15 Q -> soda 4
        tbl[16] = '{CQ, 1'b1, 3'd1};       // IDLE Q -> soda 1
        tbl[17] = '{NO, 1'b0, 3'd0};       // idle
        tbl[18] = '{CD | CQ, 1'b1, 3'd1};  // D+Q treated as Q
        tbl[19] = '{CN | CD, 1'b0, 3'd0};  // N+D treated as D -> C10
        tbl[20] = '{NO, 1'b0, 3'd0};       // hold C10
        tbl[21] = '{CN | CD | CQ, 1'b1, 3'd3}; // all three at C10 -> Q
        tbl[22] = '{NO, 1'b0, 3'd0};

        // Reset state, with coins strobing while reset is held.
        {i_quarter, i_dime, i_nickle} = CQ;
        #1;
        chk("reset_soda", {3'b0, o_soda}, 4'd0);
        chk("reset_chg", {1'b0, o_change}, 4'd0);
        @(negedge i_clk);
        @(negedge i_clk);
        chk("reset_held_soda", {3'b0, o_soda}, 4'd0);
        {i_quarter, i_dime, i_nickle} = NO;
        i_rstn = 1'b1;

        for (int i = 0; i < 23; i++) begin
            step(tbl[i].coin, tbl[i].soda, tbl[i].chg, $sformatf("tbl%0d", i));
        end

        // Single quarter: soda one cycle, then low.
        step(CQ, 1'b1, 3'd1, "q_single");
        step(NO, 1'b0, 3'd0, "q_single_after");

        // Four nickels.
        for (int i = 0; i < 3; i++) step(CN, 1'b0, 3'd0, $sformatf("nick%0d", i + 1));
        step(CN, 1'b1, 3'd0, "nick4");
        step(NO, 1'b0, 3'd0, "nick_after");

        // D, N, then Q for maximum change; credit returns to 0.
        step(CD, 1'b0, 3'd0, "dnq_d");
        step(CN, 1'b0, 3'd0, "dnq_n");
        step(CQ, 1'b1, 3'd4, "dnq_q");
        step(NO, 1'b0, 3'd0, "dnq_after");
        step(CN, 1'b0, 3'd0, "dnq_credit0_a");
        step(CN, 1'b0, 3'd0, "dnq_credit0_b");
        step(CD, 1'b1, 3'd0, "dnq_credit0_c");

        // Credit held across idle gaps between two dimes.
        for (int g = 0; g <= 5; g++) begin
            step(CD, 1'b0, 3'd0, $sformatf("gap%0d_d1", g));
            for (int k = 0; k < g; k++) step(NO, 1'b0, 3'd0, $sformatf("gap%0d_idle%0d", g, k));
            step(CD, 1'b1, 3'd0, $sformatf("gap%0d_d2", g));
        end
        step(NO, 1'b0, 3'd0, "gap_after");

        // Back-to-back quarters during the soda cycle.
        step(CQ, 1'b1, 3'd1, "qq_1");
        step(CQ, 1'b1, 3'd1, "qq_2");
        step(NO, 1'b0, 3'd0, "qq_after");

        // N, D then reset: credit lost.
        step(CN, 1'b0, 3'd0, "rst_n");
        step(CD, 1'b0, 3'd0, "rst_d");
        rst_pulse();
        step(CN, 1'b0, 3'd0, "post_rst_n1");
        step(CN, 1'b0, 3'd0, "post_rst_n2");
        step(CD, 1'b1, 3'd0, "post_rst_d");
        step(NO, 1'b0, 3'd0, "post_rst_idle");

        // Asynchronous reset in the middle of a soda pulse clears outputs at once.
        step(CQ, 1'b1, 3'd1, "async_q");
        @(posedge i_clk);
        #3;
        i_rstn = 1'b0;
        #1;
        chk("async_rst_soda", {3'b0, o_soda}, 4'd0);
        chk("async_rst_chg", {1'b0, o_change}, 4'd0);
        step(CQ, 1'b0, 3'd0, "coin_in_reset");
        @(negedge i_clk);
        {i_quarter, i_dime, i_nickle} = NO;
        i_rstn = 1'b1;
        step(CN, 1'b0, 3'd0, "after_async_n");
        step(CD, 1'b0, 3'd0, "after_async_d");
        step(CN, 1'b1, 3'd0, "after_async_n2");
        step(NO, 1'b0, 3'd0, "tail");

        repeat (3) @(posedge i_clk);
        #2;
        chk("scoreboard_drained", 4'(sb.size()), 4'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
